// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register offsets and VECTOR layout.
package intc_pkg;

    localparam logic [2:0] INTC_PEND   = 3'd0;
    localparam logic [2:0] INTC_MASK   = 3'd1;
    localparam logic [2:0] INTC_ACTIVE = 3'd2;
    localparam logic [2:0] INTC_VECTOR = 3'd3;
    localparam logic [2:0] INTC_CTRL   = 3'd4;
    localparam logic [2:0] INTC_SWSET  = 3'd5;

    localparam int INTC_VEC_VALID_BIT = 31;
    localparam int INTC_IDX_W         = 5;

endpackage

// File: rtl/intc_prienc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
module intc_prienc
    import intc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]      req_i,
    output logic                  valid_o,
    output logic [INTC_IDX_W-1:0] idx_o
);

    // Scanning high to low lets the lowest set bit overwrite last.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = INTC_IDX_W'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/intc.sv
// Memory-mapped interrupt controller with pending/mask/software-set registers.
// Define INTC_EDGE_EN for rising-edge source detection; default is level mode.
module intc
    import intc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] irqs,
    output logic             irq
);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] src_set;
    logic [WIDTH-1:0] sw_set;
    logic [WIDTH-1:0] w1c_clr;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] vector;
    logic             vec_valid;
    logic [INTC_IDX_W-1:0] vec_idx;
    logic             wr_en;

    assign wr_en = cs && wen;

`ifdef INTC_EDGE_EN
    logic [WIDTH-1:0] irqs_q;

    // Cleared in reset so a source held high across release reads as an edge.
    always_ff @(posedge clk) begin
        if (reset) irqs_q <= '0;
        else       irqs_q <= irqs;
    end

    assign src_set = irqs & ~irqs_q;
`else
    assign src_set = irqs;
`endif

    assign sw_set  = (wr_en && addr == INTC_SWSET) ? din : '0;
    assign w1c_clr = (wr_en && addr == INTC_PEND)  ? din : '0;
    assign active  = pend_q & mask_q;

    intc_prienc #(.WIDTH(WIDTH)) u_prienc (
        .req_i   (active),
        .valid_o (vec_valid),
        .idx_o   (vec_idx)
    );

    always_comb begin
        vector = '0;
        vector[INTC_IDX_W-1:0]    = vec_idx;
        vector[INTC_VEC_VALID_BIT] = vec_valid;
    end

    always_comb begin
        // Set sources are OR'd in after the clear so a coincident set wins.
        pend_d = (pend_q & ~w1c_clr) | src_set | sw_set;
        mask_d = mask_q;
        gie_d  = gie_q;
        if (wr_en && addr == INTC_MASK) mask_d = din;
        if (wr_en && addr == INTC_CTRL) gie_d  = din[0];
        irq_d = gie_q && (|active);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= '0;
            gie_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            gie_q  <= gie_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            INTC_PEND:   dout = pend_q;
            INTC_MASK:   dout = mask_q;
            INTC_ACTIVE: dout = active;
            INTC_VECTOR: dout = vector;
            INTC_CTRL:   dout = {{(WIDTH-1){1'b0}}, gie_q};
            default:     dout = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_intc.sv
// Scoreboard bench for intc: stimulus queues expected values, a monitor compares them.
module tb_intc;
    import intc_pkg::*;

    localparam int WIDTH = 32;
    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cs;
    logic             wen;
    logic [2:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] irqs;
    logic             irq;

    intc #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .wen   (wen),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irqs  (irqs),
        .irq   (irq)
    );

    always #50 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t  sb[$];
    event push_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin : monitor
        sb_t         e;
        logic [31:0] got;
        forever begin
            @(push_ev);
            #1;
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                got = (e.kind == K_RD) ? dout : {31'b0, irq};
                n_checks++;
                if (got === e.exp) n_pass++;
                else $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    end

    task automatic chk(input int kind, input logic [2:0] a, input logic [31:0] exp,
                       input string name);
        if (kind == K_RD) addr = a;
        sb.push_back('{kind, exp, name});
        -> push_ev;
        #2;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = '0; din = '0; irqs = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state: every offset reads 0, irq low.
        for (int i = 0; i < 8; i++) chk(K_RD, 3'(i), 32'h0, "reset_read");
        chk(K_IRQ, 3'd0, 32'h0, "reset_irq");

        // Timer pulse with MASK=1, GIE=1.
        wr(INTC_MASK, 32'h1);
        wr(INTC_CTRL, 32'h1);
        irqs = 32'h1;
        tick();
        irqs = 32'h0;
        chk(K_RD, INTC_PEND,   32'h1,        "pulse_pend");
        chk(K_RD, INTC_ACTIVE, 32'h1,        "pulse_active");
        chk(K_RD, INTC_VECTOR, 32'h80000000, "pulse_vector");
        chk(K_IRQ, 3'd0,       32'h0,        "pulse_irq_early");
        tick();
        chk(K_IRQ, 3'd0,       32'h1,        "pulse_irq");
        wr(INTC_PEND, 32'h1);
        chk(K_RD, INTC_PEND,   32'h0,        "w1c_pend");
        chk(K_IRQ, 3'd0,       32'h1,        "w1c_irq_lag");
        tick();
        chk(K_IRQ, 3'd0,       32'h0,        "w1c_irq");

        // Software set and priority.
        wr(INTC_MASK, 32'h0C);
        wr(INTC_SWSET, 32'h0C);
        chk(K_RD, INTC_MASK,   32'h0C,       "mask_rb");
        chk(K_RD, INTC_PEND,   32'h0C,       "swset_pend");
        chk(K_RD, INTC_ACTIVE, 32'h0C,       "swset_active");
        chk(K_RD, INTC_VECTOR, 32'h80000002, "swset_vector");
        chk(K_RD, INTC_SWSET,  32'h0,        "swset_read0");
        wr(INTC_PEND, 32'h04);
        chk(K_RD, INTC_VECTOR, 32'h80000003, "w1c_vector");
        chk(K_IRQ, 3'd0,       32'h1,        "swset_irq");
        wr(INTC_PEND, 32'h08);
        chk(K_RD, INTC_PEND,   32'h0,        "clear_all");

        // Read-only and unmapped offsets ignore writes.
        wr(INTC_ACTIVE, 32'hFFFFFFFF);
        wr(INTC_VECTOR, 32'hFFFFFFFF);
        wr(3'd6, 32'hFFFFFFFF);
        wr(3'd7, 32'hFFFFFFFF);
        chk(K_RD, INTC_ACTIVE, 32'h0,        "ro_active");
        chk(K_RD, INTC_VECTOR, 32'h0,        "ro_vector");
        chk(K_RD, 3'd6,        32'h0,        "off6");
        chk(K_RD, 3'd7,        32'h0,        "off7");
        chk(K_RD, INTC_PEND,   32'h0,        "ro_no_pend");
        chk(K_RD, INTC_MASK,   32'h0C,       "ro_no_mask");

        // Set beats a coincident W1C on the same bit.
        irqs = 32'h20;
        cs = 1'b1; wen = 1'b1; addr = INTC_PEND; din = 32'h20;
        tick();
        cs = 1'b0; wen = 1'b0; din = '0; irqs = '0;
        chk(K_RD, INTC_PEND,   32'h20,       "set_wins");
        wr(INTC_PEND, 32'h20);
        chk(K_RD, INTC_PEND,   32'h0,        "set_wins_clear");

        // Held-high source against W1C.
        irqs = 32'h2;
        tick();
        chk(K_RD, INTC_PEND,   32'h2,        "held_pend");
        wr(INTC_PEND, 32'h2);
`ifdef INTC_EDGE_EN
        chk(K_RD, INTC_PEND,   32'h0,        "held_w1c_edge");
`else
        chk(K_RD, INTC_PEND,   32'h2,        "held_w1c_level");
`endif
        irqs = 32'h0;
        wr(INTC_PEND, 32'h2);
        chk(K_RD, INTC_PEND,   32'h0,        "dropped_w1c");

        // Global enable gating, then reset overriding a concurrent write and event.
        wr(INTC_CTRL, 32'h0);
        wr(INTC_MASK, 32'h10);
        wr(INTC_SWSET, 32'h10);
        tick();
        chk(K_RD, INTC_ACTIVE, 32'h10,       "gie_active");
        chk(K_IRQ, 3'd0,       32'h0,        "gie_off_irq");
        wr(INTC_CTRL, 32'h1);
        chk(K_RD, INTC_CTRL,   32'h1,        "ctrl_rb");
        chk(K_IRQ, 3'd0,       32'h0,        "gie_on_lag");
        tick();
        chk(K_IRQ, 3'd0,       32'h1,        "gie_on_irq");
        reset = 1'b1;
        cs = 1'b1; wen = 1'b1; addr = INTC_SWSET; din = 32'hFF; irqs = 32'hFF;
        tick();
        reset = 1'b0;
        cs = 1'b0; wen = 1'b0; din = '0; irqs = '0;
        chk(K_RD, INTC_PEND,   32'h0,        "rst_pend");
        chk(K_RD, INTC_MASK,   32'h0,        "rst_mask");
        chk(K_RD, INTC_CTRL,   32'h0,        "rst_ctrl");
        chk(K_RD, INTC_VECTOR, 32'h0,        "rst_vector");
        chk(K_IRQ, 3'd0,       32'h0,        "rst_irq");

        // Source held high through reset release is captured once released.
        reset = 1'b1;
        irqs = 32'h8;
        tick();
        reset = 1'b0;
        chk(K_RD, INTC_PEND,   32'h0,        "rel_pend_before");
        tick();
        chk(K_RD, INTC_PEND,   32'h8,        "rel_pend_after");
        irqs = '0;
        tick();

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
